// File: rtl/axi_lite_ram_slave.sv
// ---------------------------------------------------------------------------
// axi_lite_ram_slave
//   AXI4-Lite target backed by a DEPTH x 32-bit word RAM. The write and read
//   channels are served by two independent FSMs, each allowing one transaction
//   in flight. Byte lanes are written per i_wstrb. Accesses whose word index
//   is at or above DEPTH return SLVERR and never touch the RAM. o_err_cnt
//   counts every SLVERR response issued and saturates at 255.
//
// Ports
//   i_clk, i_rst_n                 clock (rising edge), async active-low reset
//   i_awaddr/i_awvalid/o_awready   write address channel
//   i_wdata/i_wstrb/i_wvalid/o_wready  write data channel
//   o_bresp/o_bvalid/i_bready      write response channel
//   i_araddr/i_arvalid/o_arready   read address channel
//   o_rdata/o_rresp/o_rlast/o_rvalid/i_rready  read data channel
//   o_err_cnt                      saturating SLVERR counter
// ---------------------------------------------------------------------------
module axi_lite_ram_slave #(
    parameter int AW    = 12,
    parameter int DEPTH = 256
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [AW-1:0] i_awaddr,
    input  logic          i_awvalid,
    output logic          o_awready,
    input  logic [31:0]   i_wdata,
    input  logic [3:0]    i_wstrb,
    input  logic          i_wvalid,
    output logic          o_wready,
    output logic [1:0]    o_bresp,
    output logic          o_bvalid,
    input  logic          i_bready,
    input  logic [AW-1:0] i_araddr,
    input  logic          i_arvalid,
    output logic          o_arready,
    output logic [31:0]   o_rdata,
    output logic [1:0]    o_rresp,
    output logic          o_rlast,
    output logic          o_rvalid,
    input  logic          i_rready,
    output logic [7:0]    o_err_cnt
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] WR_IDLE    = 2'd0;
    localparam logic [1:0] WR_WAIT_W  = 2'd1;
    localparam logic [1:0] WR_WAIT_AW = 2'd2;
    localparam logic [1:0] WR_RESP    = 2'd3;

    localparam logic [0:0] RD_IDLE = 1'b0;
    localparam logic [0:0] RD_DATA = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic in_range(input logic [AW-1:0] addr);
        return 32'(addr[AW-1:2]) < 32'(DEPTH);
    endfunction

    function automatic logic [IW-1:0] word_idx(input logic [AW-1:0] addr);
        return addr[IW+1:2];
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] cnt, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, cnt} + {7'b0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    logic [31:0]   mem [DEPTH];

    logic [1:0]    wr_state;
    logic [0:0]    rd_state;
    logic          rdy_en;
    logic [AW-1:0] wr_addr_q;
    logic [31:0]   wr_data_q;
    logic [3:0]    wr_strb_q;

    logic          aw_hs, w_hs, ar_hs;
    logic          commit, cm_ok, ar_ok;
    logic [AW-1:0] cm_addr;
    logic [31:0]   cm_data;
    logic [3:0]    cm_strb;
    logic          b_err_new, r_err_new;

    logic          unused_addr_lsbs;
    assign unused_addr_lsbs = ^{i_awaddr[1:0], i_araddr[1:0], wr_addr_q[1:0]};

    // Readies come from registered state only; rdy_en holds them low through
    // reset and for the first edge after release.
    assign o_awready = rdy_en && (wr_state == WR_IDLE || wr_state == WR_WAIT_AW);
    assign o_wready  = rdy_en && (wr_state == WR_IDLE || wr_state == WR_WAIT_W);
    assign o_bvalid  = (wr_state == WR_RESP);
    assign o_arready = rdy_en && (rd_state == RD_IDLE);
    assign o_rvalid  = (rd_state == RD_DATA);
    assign o_rlast   = 1'b1;

    assign aw_hs = i_awvalid && o_awready;
    assign w_hs  = i_wvalid && o_wready;
    assign ar_hs = i_arvalid && o_arready;

    // A write commits on the cycle its second half (or both halves) arrives;
    // whichever half came first is taken from the latches.
    always_comb begin
        commit = 1'b0;
        unique case (wr_state)
            WR_IDLE:    commit = aw_hs && w_hs;
            WR_WAIT_W:  commit = w_hs;
            WR_WAIT_AW: commit = aw_hs;
            default:    commit = 1'b0;
        endcase
    end

    assign cm_addr = (wr_state == WR_WAIT_W)  ? wr_addr_q : i_awaddr;
    assign cm_data = (wr_state == WR_WAIT_AW) ? wr_data_q : i_wdata;
    assign cm_strb = (wr_state == WR_WAIT_AW) ? wr_strb_q : i_wstrb;
    assign cm_ok   = in_range(cm_addr);
    assign ar_ok   = in_range(i_araddr);

    assign b_err_new = commit && !cm_ok;
    assign r_err_new = ar_hs && !ar_ok;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    // Write channel FSM
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_state  <= WR_IDLE;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_strb_q <= '0;
            o_bresp   <= RESP_OKAY;
        end else if (commit) begin
            wr_state <= WR_RESP;
            o_bresp  <= cm_ok ? RESP_OKAY : RESP_SLVERR;
        end else begin
            unique case (wr_state)
                WR_IDLE: begin
                    if (aw_hs) begin
                        wr_addr_q <= i_awaddr;
                        wr_state  <= WR_WAIT_W;
                    end else if (w_hs) begin
                        wr_data_q <= i_wdata;
                        wr_strb_q <= i_wstrb;
                        wr_state  <= WR_WAIT_AW;
                    end
                end
                WR_RESP: begin
                    if (i_bready) begin
                        wr_state <= WR_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM array: not reset, survives reset pulses.
    always_ff @(posedge i_clk) begin
        if (commit && cm_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (cm_strb[b]) begin
                    mem[word_idx(cm_addr)][8*b +: 8] <= cm_data[8*b +: 8];
                end
            end
        end
    end

    // Read channel FSM; the RAM is sampled before any same-edge write lands,
    // so a colliding read returns the old word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_state <= RD_IDLE;
            o_rdata  <= '0;
            o_rresp  <= RESP_OKAY;
        end else begin
            unique case (rd_state)
                RD_IDLE: begin
                    if (ar_hs) begin
                        rd_state <= RD_DATA;
                        o_rdata  <= ar_ok ? mem[word_idx(i_araddr)] : 32'd0;
                        o_rresp  <= ar_ok ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                default: begin
                    if (i_rready) begin
                        rd_state <= RD_IDLE;
                    end
                end
            endcase
        end
    end

    // Counted on the edge the SLVERR response becomes visible.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_err_cnt <= '0;
        end else if (b_err_new || r_err_new) begin
            o_err_cnt <= sat_add(o_err_cnt, {1'b0, b_err_new} + {1'b0, r_err_new});
        end
    end

endmodule
